// File: rtl/div16_if.sv
// div16_if: operand/result handshake bundle for the div16 fixed-point divider.
//   in_valid / in_ready  : operand handshake (producer -> divider)
//   in_17bit             : signed dividend, DW bits
//   in_8bit              : signed Q1.7 divisor, CW bits
//   out_valid / out_ready: result handshake (divider -> consumer)
//   out                  : signed saturated quotient, DW bits
//   ovf                  : quotient was saturated
//   err                  : divide by zero
// Modports: master = operand producer / result consumer, slave = divider.
interface div16_if #(
    parameter int DW = 17,
    parameter int CW = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_17bit;
    logic signed [CW-1:0] in_8bit;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out;
    logic                 ovf;
    logic                 err;

    modport master (
        output in_valid, in_17bit, in_8bit, out_ready,
        input  in_ready, out_valid, out, ovf, err
    );

    modport slave (
        input  in_valid, in_17bit, in_8bit, out_ready,
        output in_ready, out_valid, out, ovf, err
    );
endinterface

// File: rtl/div16.sv
// div16: sequential fixed-point divider, out = (in_17bit <<< FRAC) / in_8bit.
// Inverse of the multi16 scaling stage: undoes Q1.7 twiddle/gain scaling on
// 17-bit butterfly samples. Radix-2 restoring division on magnitudes, one
// quotient bit per cycle; the sign is reapplied and the result saturated
// in a final fix-up cycle.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : div16_if slave (operand handshake in, result handshake out)
// Latency: acceptance edge E0 -> out_valid high after edge E0+25.
module div16 #(
    parameter int DW   = 17,
    parameter int CW   = 8,
    parameter int FRAC = 7
) (
    input logic   clk,
    input logic   rst,
    div16_if.slave bus
);
    localparam int QW    = DW + FRAC;      // magnitude of a<<FRAC
    localparam int RW    = CW + 1;         // remainder must hold up to 2*|b|-1
    localparam int CNT_W = $clog2(QW);

    localparam logic [DW-1:0] POS_LIM = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] NEG_LIM = {1'b1, {(DW-1){1'b0}}};
    localparam logic [QW-1:0] POS_MAG = QW'(POS_LIM);
    localparam logic [QW-1:0] NEG_MAG = QW'(NEG_LIM);

    typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

    state_t state_q, state_d;

    logic [QW-1:0]        q_reg;
    logic [RW-1:0]        rem_reg;
    logic [CW-1:0]        dvs_reg;
    logic [CNT_W-1:0]     cnt;
    logic                 sa, za, sgn_a, a_zero;
    logic signed [DW-1:0] out_reg;
    logic                 ovf_reg, err_reg;

    logic                 accept;
    logic [DW-1:0]        a_mag;
    logic [CW-1:0]        b_mag;
    logic [RW-1:0]        rem_sh;
    logic                 rem_ge;
    logic [DW:0]          fix_res;

    // Clamp the unsigned quotient magnitude into the signed result range and
    // reapply the sign; returns {ovf, out}. Negative side reaches one further.
    function automatic logic [DW:0] sat_quot(input logic [QW-1:0] q, input logic neg);
        if (!neg && q > POS_MAG)
            return {1'b1, POS_LIM};
        else if (neg && q > NEG_MAG)
            return {1'b1, NEG_LIM};
        else if (neg)
            return {1'b0, DW'(~q[DW-1:0] + 1'b1)};
        else
            return {1'b0, q[DW-1:0]};
    endfunction

    // Divide-by-zero result: the limit in the direction of the dividend.
    function automatic logic [DW:0] zero_div(input logic a_is_zero, input logic a_neg);
        if (a_is_zero)
            return '0;
        else if (a_neg)
            return {1'b0, NEG_LIM};
        else
            return {1'b0, POS_LIM};
    endfunction

    assign accept = bus.in_valid && (state_q == IDLE);

    // |-65536| = 65536 still fits as a 17-bit unsigned value; |-128| = 128 fits in 8.
    assign a_mag = bus.in_17bit[DW-1] ? (~bus.in_17bit + 1'b1) : bus.in_17bit;
    assign b_mag = bus.in_8bit[CW-1]  ? (~bus.in_8bit + 1'b1)  : bus.in_8bit;

    assign rem_sh  = {rem_reg[RW-2:0], q_reg[QW-1]};
    assign rem_ge  = rem_sh >= {1'b0, dvs_reg};
    assign fix_res = za ? zero_div(a_zero, sgn_a) : sat_quot(q_reg, sa);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid)                   state_d = DIV;
            DIV:  if (cnt == CNT_W'(QW - 1))          state_d = FIX;
            FIX:                                      state_d = DONE;
            DONE: if (bus.out_ready)                  state_d = IDLE;
            default:                                  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg   <= '0;
            rem_reg <= '0;
            dvs_reg <= '0;
            cnt     <= '0;
            sa      <= 1'b0;
            za      <= 1'b0;
            sgn_a   <= 1'b0;
            a_zero  <= 1'b0;
            out_reg <= '0;
            ovf_reg <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            // operand capture
            if (accept) begin
                sa      <= bus.in_17bit[DW-1] ^ bus.in_8bit[CW-1];
                za      <= (bus.in_8bit == '0);
                sgn_a   <= bus.in_17bit[DW-1];
                a_zero  <= (bus.in_17bit == '0);
                q_reg   <= {a_mag, {FRAC{1'b0}}};
                dvs_reg <= b_mag;
                rem_reg <= '0;
                cnt     <= '0;
            end
            // restoring-division iteration
            if (state_q == DIV) begin
                if (rem_ge) begin
                    rem_reg <= rem_sh - {1'b0, dvs_reg};
                    q_reg   <= {q_reg[QW-2:0], 1'b1};
                end else begin
                    rem_reg <= rem_sh;
                    q_reg   <= {q_reg[QW-2:0], 1'b0};
                end
                cnt <= cnt + 1'b1;
            end
            // sign / saturation fix-up
            if (state_q == FIX) begin
                ovf_reg <= fix_res[DW];
                out_reg <= fix_res[DW-1:0];
                err_reg <= za;
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = out_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.err       = err_reg;
endmodule
